// File: rtl/bus_pkg.sv
// Shared types and constants for the instruction-sequencing controller.
// Holds the step enum, opcodes and bus-mux select helpers.
package bus_pkg;

    typedef enum logic [1:0] {
        T0,
        T1,
        T2,
        T3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    localparam int SEL_DIN = 0;
    localparam int SEL_R0  = 1;
    localparam int SEL_PC  = 8;
    localparam int SEL_G   = 9;

    // One-hot bus-mux select with bit 0 = din and bit 9 = g.
    function automatic logic [0:9] reg_sel(input int idx);
        logic [0:9] v;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            v[i] = (idx == i);
        end
        return v;
    endfunction

endpackage

// File: rtl/bus_reg_decoder.sv
// 3-bit register index to one-hot decoder with enable.
// Index 7 lands on the last bit, which the top maps to the PC.
module reg_decoder (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [0:7] oh
);

    // Single hot bit at idx when enabled, all-zero otherwise.
    always_comb begin
        oh = '0;
        if (en) begin
            oh[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// Instruction-sequencing FSM: fetches III XXX YYY from din and
// steps through T0..T3 driving mux selects and register enables.
module bus_controller
    import bus_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] din,
    input  logic        gnz,
    output logic [0:9]  bus_sel,
    output logic [0:6]  r_in,
    output logic        pc_in,
    output logic        pc_incr,
    output logic        ir_in,
    output logic        a_in,
    output logic        g_in,
    output logic        addsub,
    output logic        done
);

    state_t     state;
    state_t     state_nx;
    logic [8:0] ir;
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic       dst_en;
    logic       src_en;
    logic [2:0] src_idx;
    logic [0:9] fix_sel;
    logic [0:7] dst_oh;
    logic [0:7] src_oh;
    logic       unused_din;

    assign op = ir[8:6];
    assign x  = ir[5:3];
    assign y  = ir[2:0];

    assign unused_din = ^din[15:9];

    // Step register and instruction latch; reset aborts any instruction.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (ir_in) begin
                ir <= din[8:0];
            end
        end
    end

    // Next step and all control strobes from the current step and IR.
    always_comb begin
        state_nx = state;
        ir_in    = 1'b0;
        pc_incr  = 1'b0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        dst_en   = 1'b0;
        src_en   = 1'b0;
        src_idx  = 3'd0;
        fix_sel  = '0;
        unique case (state)
            T0: begin
                if (run && resetn) begin
                    ir_in    = 1'b1;
                    pc_incr  = 1'b1;
                    state_nx = T1;
                end
            end
            T1: begin
                done     = 1'b1;
                state_nx = T0;
                case (op)
                    OP_MV: begin
                        src_en  = 1'b1;
                        src_idx = y;
                        dst_en  = 1'b1;
                    end
                    OP_MVI: begin
                        fix_sel = reg_sel(SEL_DIN);
                        dst_en  = 1'b1;
                        pc_incr = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        done     = 1'b0;
                        src_en   = 1'b1;
                        src_idx  = x;
                        a_in     = 1'b1;
                        state_nx = T2;
                    end
                    OP_MVNZ: begin
                        if (gnz) begin
                            src_en  = 1'b1;
                            src_idx = y;
                            dst_en  = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            T2: begin
                src_en   = 1'b1;
                src_idx  = y;
                g_in     = 1'b1;
                addsub   = ir[6];
                state_nx = T3;
            end
            T3: begin
                fix_sel  = reg_sel(SEL_G);
                dst_en   = 1'b1;
                done     = 1'b1;
                state_nx = T0;
            end
            default: begin
                state_nx = T0;
            end
        endcase
    end

    reg_decoder u_dst (
        .en  (dst_en),
        .idx (x),
        .oh  (dst_oh)
    );

    reg_decoder u_src (
        .en  (src_en),
        .idx (src_idx),
        .oh  (src_oh)
    );

    assign r_in  = dst_oh[0:6];
    assign pc_in = dst_oh[7];

    // Merge the register/pc source with the fixed din/g selects.
    always_comb begin
        bus_sel = fix_sel;
        for (int i = 0; i < 8; i++) begin
            bus_sel[SEL_R0+i] = bus_sel[SEL_R0+i] | src_oh[i];
        end
    end

endmodule
